// File: rtl/memory_stage_if.sv
// memory_stage_if: req/ack data bus between the M stage (master) and data memory / timer (slave).
interface memory_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ack, bus_rdata);
    modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/memory_stage.sv
// memory_stage: P7 M stage - E/M register, ld/st address exceptions, req/ack bus access, load extension.
// Optional BUS_TIMEOUT_EN: abandon a WAIT after MAX_WAIT cycles with an address-error exception.
module memory_stage #(
`ifdef BUS_TIMEOUT_EN
    parameter int          MAX_WAIT  = 16,
`endif
    parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
    parameter logic [31:0] TMR_BASE  = 32'h0000_7F00,
    parameter logic [31:0] TMR_LIMIT = 32'h0000_7F1B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrE,
    input  logic [4:0]  A3EM,
    input  logic [31:0] WDEM,
    input  logic [31:0] ResEM,
    input  logic [31:0] RD2EM,
    input  logic [4:0]  ExcCodeEM,
    input  logic        flush,
    output logic [31:0] InstrM,
    output logic [4:0]  A3M,
    output logic [31:0] WDM,
    output logic [4:0]  ExcCodeM,
    output logic        stall_m,
    memory_stage_if.master bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;
    logic [31:0] instr_r, wd_r, res_r, rd2_r;
    logic [4:0]  a3_r, exc_r;
    logic        flush_pend, kill, timeout;
    logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb, is_load, is_store;
    logic        in_dm, in_tmr, addr_bad;
    logic [15:0] half;
    logic [7:0]  byte_s;
    logic [31:0] ld;
`ifdef BUS_TIMEOUT_EN
    logic [7:0]  cnt;
    assign timeout = state == WAIT && cnt == 8'(MAX_WAIT);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        is_lw    = instr_r[31:26] == 6'h23;
        is_lh    = instr_r[31:26] == 6'h21;
        is_lhu   = instr_r[31:26] == 6'h25;
        is_lb    = instr_r[31:26] == 6'h20;
        is_lbu   = instr_r[31:26] == 6'h24;
        is_sw    = instr_r[31:26] == 6'h2B;
        is_sh    = instr_r[31:26] == 6'h29;
        is_sb    = instr_r[31:26] == 6'h28;
        is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
        is_store = is_sw | is_sh | is_sb;
        in_dm    = res_r <= DM_LIMIT;
        in_tmr   = res_r >= TMR_BASE && res_r <= TMR_LIMIT;
        // timer registers are word-wide only, so partial stores there fault
        addr_bad = (is_load | is_store) && (((is_lw | is_sw) && res_r[1:0] != 2'b00) ||
                   ((is_lh | is_lhu | is_sh) && res_r[0]) || (!in_dm && !in_tmr) ||
                   ((is_sh | is_sb) && in_tmr));
        ExcCodeM = exc_r != 5'd0 ? exc_r : (addr_bad || timeout) ? (is_load ? 5'd4 : 5'd5) : 5'd0;
        A3M      = ExcCodeM != 5'd0 ? 5'd0 : a3_r;
        InstrM   = instr_r;
        bus.bus_req   = (is_load | is_store) && exc_r == 5'd0 && !addr_bad && !timeout;
        bus.bus_we    = bus.bus_req && is_store;
        bus.bus_addr  = {res_r[31:2], 2'b00};
        bus.bus_be    = !bus.bus_req ? 4'b0000 : is_sh ? (res_r[1] ? 4'b1100 : 4'b0011) :
                        is_sb ? 4'b0001 << res_r[1:0] : 4'b1111;
        bus.bus_wdata = is_sw ? rd2_r : is_sh ? {2{rd2_r[15:0]}} : is_sb ? {4{rd2_r[7:0]}} : 32'd0;
        half     = res_r[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        byte_s   = bus.bus_rdata[{res_r[1:0], 3'b000} +: 8];
        ld       = is_lw ? bus.bus_rdata : (is_lh | is_lhu) ? {{16{is_lh & half[15]}}, half} :
                   {{24{is_lb & byte_s[7]}}, byte_s};
        WDM      = is_load ? ld : wd_r;
        stall_m  = bus.bus_req && !bus.bus_ack;
        state_nx = stall_m ? WAIT : IDLE;
        kill     = flush || flush_pend;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            instr_r    <= '0;
            a3_r       <= '0;
            wd_r       <= '0;
            res_r      <= '0;
            rd2_r      <= '0;
            exc_r      <= '0;
        end else begin
            state      <= state_nx;
            flush_pend <= stall_m && kill;
            if (!stall_m) begin
                instr_r <= kill ? '0 : InstrE;
                a3_r    <= kill ? '0 : A3EM;
                wd_r    <= kill ? '0 : WDEM;
                res_r   <= kill ? '0 : ResEM;
                rd2_r   <= kill ? '0 : RD2EM;
                exc_r   <= kill ? '0 : ExcCodeEM;
            end
        end
    end
`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else cnt <= (state == WAIT && stall_m) ? cnt + 8'd1 : 8'd0;
    end
`endif
endmodule
